// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receiver, 8-bit LSB-first frames with optional parity
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [PRESCALE_W-1:0]   ps_lat;
  logic                    par_en_lat;
  logic                    par_typ_lat;
  logic [BIT_W-1:0]        bit_cnt;
  logic [2:0]              samples;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    frame_bad;

  logic                    prescale_legal;
  logic [PRESCALE_W-1:0]   half;
  logic                    last_edge;
  logic                    majority;
  logic                    start_now;
  logic                    dv_nxt;
  logic                    pe_nxt;
  logic                    se_nxt;

  // Only 8, 16 and 32 oversampling ratios are accepted; anything else keeps the line ignored.
  assign prescale_legal = (Prescale == PRESCALE_W'(8)) ||
                          (Prescale == PRESCALE_W'(16)) ||
                          (Prescale == PRESCALE_W'(32));
  assign half      = ps_lat >> 1;
  assign last_edge = (edge_cnt == (ps_lat - ONE));
  assign majority  = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  // A new start bit begins either from IDLE or straight out of STOP (back-to-back frames).
  assign start_now = (state_nxt == START) && ((state == IDLE) || (state == STOP));

  // Next-state and output-pulse decisions; every bit decision happens at the last edge of the bit.
  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN && prescale_legal) state_nxt = START;
      end
      START: begin
        if (last_edge) state_nxt = majority ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge && (bit_cnt == BIT_W'(DATA_WIDTH - 1)))
          state_nxt = par_en_lat ? PARITY : STOP;
      end
      PARITY: begin
        if (last_edge) begin
          pe_nxt    = (majority != ((^shift) ^ par_typ_lat));
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          se_nxt    = !majority;
          dv_nxt    = majority && !frame_bad;
          state_nxt = (!RX_IN && prescale_legal) ? START : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bit timing, config latch, oversampling and shift register; the start cycle counts as edge 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      ps_lat      <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      bit_cnt     <= '0;
      samples     <= '0;
      shift       <= '0;
      frame_bad   <= 1'b0;
    end else if (start_now) begin
      edge_cnt    <= ONE;
      ps_lat      <= Prescale;
      par_en_lat  <= PAR_EN;
      par_typ_lat <= PAR_TYP;
      bit_cnt     <= '0;
      frame_bad   <= 1'b0;
    end else if (state != IDLE) begin
      edge_cnt <= last_edge ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) samples[0] <= RX_IN;
      if (edge_cnt == half)       samples[1] <= RX_IN;
      if (edge_cnt == half + ONE) samples[2] <= RX_IN;
      if ((state == DATA) && last_edge) begin
        shift   <= {majority, shift[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (pe_nxt || se_nxt) frame_bad <= 1'b1;
    end else begin
      edge_cnt <= '0;
    end
  end

  // Registered outputs: single-cycle pulses, and P_DATA only moves on a good frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= dv_nxt;
      parity_error <= pe_nxt;
      stop_error   <= se_nxt;
      if (dv_nxt) P_DATA <= shift;
    end
  end

endmodule
